// File: rtl/mv_solve_pkg.sv
// mv_pkg: shared definitions for the 2x2 fixed-point solver.
//   state_t      FSM encoding (IDLE/PREP/DIV/DONE)
//   DEF_WIDTH    default operand width (Q2.30 format)
//   DEF_FRAC     default fractional bits
//   fx_max/min   largest/smallest signed value of a w-bit operand (64-bit container)
//   fx_one       fixed-point 1.0 for f fractional bits
//   div_iters    restoring-divider iteration count, one quotient bit per cycle
package mv_pkg;
  typedef enum logic [1:0] {S_IDLE, S_PREP, S_DIV, S_DONE} state_t;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_FRAC  = 30;

  function automatic logic [63:0] fx_max(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] fx_min(input int w);
    return ~fx_max(w);
  endfunction

  function automatic logic [63:0] fx_one(input int f);
    return 64'd1 << f;
  endfunction

  function automatic int div_iters(input int w, input int f);
    return w + f;
  endfunction
endpackage

// File: rtl/mv_solve_fx_div_seq.sv
// fx_div_seq: unsigned restoring divider, one quotient bit per cycle.
//   clk, rst     clock, async active-high reset (clears all state)
//   start        load dividend/divisor; the first quotient bit is produced on this edge
//   dividend     ITERS-bit unsigned dividend
//   divisor      WIDTH-bit unsigned divisor (non-zero)
//   busy         iterations remaining
//   done         quotient final; held until the next start
//   quo          low WIDTH bits of the quotient
//   ovf          quotient >= 2^(WIDTH-1)
module fx_div_seq #(
  parameter int WIDTH = 32,
  parameter int ITERS = 62
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [ITERS-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quo,
  output logic             ovf
);
  localparam int CW = $clog2(ITERS);

  logic [ITERS-1:0] dvd_r, quo_r, src_dvd, src_quo;
  logic [WIDTH-1:0] rem_r, dsr_r, src_rem, src_dsr, rem_n;
  logic [WIDTH:0]   trial;
  logic [CW-1:0]    cnt;
  logic             ge;

  // Iteration 1 runs on the start edge straight from the inputs, so the
  // whole division spans exactly ITERS edges starting with start.
  always_comb begin
    src_dvd = start ? dividend : dvd_r;
    src_quo = start ? '0 : quo_r;
    src_rem = start ? '0 : rem_r;
    src_dsr = start ? divisor : dsr_r;
    trial   = {src_rem, src_dvd[ITERS-1]};
    ge      = trial >= {1'b0, src_dsr};
    rem_n   = ge ? WIDTH'(trial - {1'b0, src_dsr}) : trial[WIDTH-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dvd_r <= '0;
      quo_r <= '0;
      rem_r <= '0;
      dsr_r <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else if (start || busy) begin
      dvd_r <= src_dvd << 1;
      quo_r <= {src_quo[ITERS-2:0], ge};
      rem_r <= rem_n;
      dsr_r <= src_dsr;
      if (start) begin
        cnt  <= CW'(ITERS - 1);
        busy <= 1'b1;
        done <= 1'b0;
      end else begin
        cnt <= cnt - CW'(1);
        if (cnt == CW'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  assign quo = quo_r[WIDTH-1:0];
  assign ovf = |quo_r[ITERS-1:WIDTH-1];
endmodule

// File: rtl/mv_solve.sv
// mv_solve: solves M*v = b for a 2x2 signed fixed-point matrix by Cramer's rule.
//   clk, rst          clock, async active-high reset
//   in_valid/ready    operand handshake; in_ready only while idle
//   x00..x11, bx, by  matrix and right-hand vector (signed, FRAC_WIDTH fractional bits)
//   out_valid/ready   result handshake; result held until out_ready
//   ox, oy            solution vector
//   singular          det == 0 (result forced to zero, divide skipped)
//   ovf               det, a numerator or a quotient left the WIDTH range
// Build option MV_SOLVE_SAT_EN: out-of-range values clamp to the signed limits;
// without it the low WIDTH bits are kept. ovf is identical in both builds.
module mv_solve
  import mv_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int FRAC_WIDTH = DEF_FRAC
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] x00,
  input  logic signed [WIDTH-1:0] x01,
  input  logic signed [WIDTH-1:0] x10,
  input  logic signed [WIDTH-1:0] x11,
  input  logic signed [WIDTH-1:0] bx,
  input  logic signed [WIDTH-1:0] by,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] ox,
  output logic signed [WIDTH-1:0] oy,
  output logic                    singular,
  output logic                    ovf
);
  localparam int PW    = 2 * WIDTH + 1;
  localparam int ITERS = div_iters(WIDTH, FRAC_WIDTH);
`ifdef MV_SOLVE_SAT_EN
  localparam logic [63:0]      MAX64 = fx_max(WIDTH);
  localparam logic [63:0]      MIN64 = fx_min(WIDTH);
  localparam logic [WIDTH-1:0] MAXV  = MAX64[WIDTH-1:0];
  localparam logic [WIDTH-1:0] MINV  = MIN64[WIDTH-1:0];
`endif

  state_t state, state_n;
  logic signed [WIDTH-1:0] a00, a01, a10, a11, va, vb;
  logic [1:0]              neg;
  logic                    ovf_p;
  logic [1:0][WIDTH-1:0]   res_r, res, num_w, quo;
  logic [1:0]              dv_busy, dv_done, dv_ovf;
  logic [WIDTH:0]          det_c, nx_c, ny_c;
  logic [WIDTH-1:0]        det_w;
  logic                    sing_c, dv_start, dv_fin, prep_ovf;

  // Rescale a full-precision product difference; returns {ovf, value}.
  function automatic logic [WIDTH:0] scale(input logic signed [PW-1:0] v);
    logic signed [PW-1:0] s;
    logic                 o;
    s = v >>> FRAC_WIDTH;
    o = !((&s[PW-1:WIDTH-1]) || !(|s[PW-1:WIDTH-1]));
`ifdef MV_SOLVE_SAT_EN
    if (o) return {1'b1, s[PW-1] ? MINV : MAXV};
`endif
    return {o, s[WIDTH-1:0]};
  endfunction

  // Unsigned WIDTH bits hold 2^(WIDTH-1), so the most negative operand
  // yields its true magnitude rather than wrapping.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? -v : v;
  endfunction

  always_comb begin
    det_c    = scale(PW'(a00) * PW'(a11) - PW'(a01) * PW'(a10));
    nx_c     = scale(PW'(va) * PW'(a11) - PW'(a01) * PW'(vb));
    ny_c     = scale(PW'(a00) * PW'(vb) - PW'(a10) * PW'(va));
    det_w    = det_c[WIDTH-1:0];
    num_w[0] = nx_c[WIDTH-1:0];
    num_w[1] = ny_c[WIDTH-1:0];
    // Singular is judged on the divisor actually used, so a wrapped det of
    // zero never reaches the dividers.
    sing_c   = (det_w == '0);
    prep_ovf = det_c[WIDTH] | nx_c[WIDTH] | ny_c[WIDTH];
  end

  assign dv_start = (state == S_PREP) && !sing_c;
  assign dv_fin   = (dv_done == 2'b11) && (dv_busy == 2'b00);

  for (genvar i = 0; i < 2; i++) begin : g_div
    fx_div_seq #(.WIDTH(WIDTH), .ITERS(ITERS)) u_div (
      .clk      (clk),
      .rst      (rst),
      .start    (dv_start),
      .dividend ({mag(num_w[i]), {FRAC_WIDTH{1'b0}}}),
      .divisor  (mag(det_w)),
      .busy     (dv_busy[i]),
      .done     (dv_done[i]),
      .quo      (quo[i]),
      .ovf      (dv_ovf[i])
    );
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      res[i] = neg[i] ? -quo[i] : quo[i];
`ifdef MV_SOLVE_SAT_EN
      if (dv_ovf[i]) res[i] = neg[i] ? MINV : MAXV;
`endif
    end
  end

  always_comb begin
    state_n   = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_n = S_PREP;
      end
      S_PREP:  state_n = sing_c ? S_DONE : S_DIV;
      S_DIV:   if (dv_fin) state_n = S_DONE;
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      a00      <= '0;
      a01      <= '0;
      a10      <= '0;
      a11      <= '0;
      va       <= '0;
      vb       <= '0;
      neg      <= '0;
      ovf_p    <= 1'b0;
      res_r    <= '0;
      singular <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      state <= state_n;
      if (in_valid && in_ready) begin
        a00 <= x00;
        a01 <= x01;
        a10 <= x10;
        a11 <= x11;
        va  <= bx;
        vb  <= by;
      end
      if (state == S_PREP) begin
        neg[0] <= num_w[0][WIDTH-1] ^ det_w[WIDTH-1];
        neg[1] <= num_w[1][WIDTH-1] ^ det_w[WIDTH-1];
        ovf_p  <= prep_ovf;
        if (sing_c) begin
          res_r    <= '0;
          singular <= 1'b1;
          ovf      <= prep_ovf;
        end
      end
      if (state == S_DIV && dv_fin) begin
        res_r    <= res;
        singular <= 1'b0;
        ovf      <= ovf_p | (|dv_ovf);
      end
    end
  end

  assign ox = res_r[0];
  assign oy = res_r[1];
endmodule

// File: tb/tb_mv_solve.sv
// Scoreboard bench for mv_solve: the stimulus pushes hand-computed results,
// a monitor pops and compares them when the result handshake happens.
module tb_mv_solve;
  logic        clk = 1'b0, rst = 1'b1;
  logic        in_valid = 1'b0, out_ready = 1'b1;
  logic        in_ready, out_valid, singular, ovf;
  logic [31:0] x00 = '0, x01 = '0, x10 = '0, x11 = '0, bx = '0, by = '0;
  logic [31:0] ox, oy;

  mv_solve dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .x00(x00), .x01(x01), .x10(x10), .x11(x11), .bx(bx), .by(by),
    .out_valid(out_valid), .out_ready(out_ready),
    .ox(ox), .oy(oy), .singular(singular), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ox, oy;
    logic        sing, ovf;
    int          lat;
    longint      t_acc;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0, n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic tmo(input string nm);
    n_chk++;
    $display("FAIL %s: timeout waiting for DUT", nm);
  endtask

  function automatic exp_t mk(input logic [31:0] eox, eoy, input logic es, eo, input int el);
    exp_t e;
    e.ox = eox; e.oy = eoy; e.sing = es; e.ovf = eo; e.lat = el; e.t_acc = 0;
    return e;
  endfunction

  // Monitor: samples 1 time unit after the negedge, ahead of the next posedge.
  int  lat_seen = 0;
  bit  seen = 0;
  always begin
    @(negedge clk);
    #1;
    if (out_valid && !seen && q.size() != 0) begin
      seen     = 1;
      lat_seen = int'(($time - 6 - q[0].t_acc) / 10) + 1;
    end
    if (out_valid && out_ready) begin
      if (q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_result: ox %0h with empty scoreboard", ox);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("ox", ox, e.ox);
        chk("oy", oy, e.oy);
        chk("singular", singular, e.sing);
        chk("ovf", ovf, e.ovf);
        chk("latency", lat_seen, e.lat);
      end
      seen = 0;
    end
  end

  task automatic send(input logic [31:0] m00, m01, m10, m11, vx, vy, input exp_t e);
    int n;
    @(negedge clk);
    x00 = m00; x01 = m01; x10 = m10; x11 = m11; bx = vx; by = vy;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      tmo("accept");
      in_valid = 1'b0;
      return;
    end
    e.t_acc = $time + 5;
    q.push_back(e);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int n;
    n = 0;
    while (q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      tmo(nm);
      q.delete();
    end
  endtask

  localparam logic [31:0] ONE = 32'h4000_0000;

  initial begin
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_ox", ox, 0);
    chk("rst_oy", oy, 0);
    chk("rst_singular", singular, 0);
    chk("rst_ovf", ovf, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Identity, b = (0.5, -0.25)
    send(ONE, 0, 0, ONE, 32'h2000_0000, 32'hF000_0000,
         mk(32'h2000_0000, 32'hF000_0000, 0, 0, 64));
    wait_done("identity");

    // diag(0.5,0.5), b = (0.25, -0.25)
    send(32'h2000_0000, 0, 0, 32'h2000_0000, 32'h1000_0000, 32'hF000_0000,
         mk(32'h2000_0000, 32'hE000_0000, 0, 0, 64));
    wait_done("diag_half");

    // [1 1; 1 1] singular
    send(ONE, ONE, ONE, ONE, ONE, 0, mk(0, 0, 1, 0, 2));
    wait_done("singular");

    // diag(0.25,0.25), b = (1.5, 0): quotient 6.0 out of range
`ifdef MV_SOLVE_SAT_EN
    send(32'h1000_0000, 0, 0, 32'h1000_0000, 32'h6000_0000, 0,
         mk(32'h7FFF_FFFF, 0, 0, 1, 64));
`else
    send(32'h1000_0000, 0, 0, 32'h1000_0000, 32'h6000_0000, 0,
         mk(32'h8000_0000, 0, 0, 1, 64));
`endif
    wait_done("quot_ovf");

    // Swap matrix, negative det: b = (0.5, 0.25) -> v = (0.25, 0.5)
    send(0, ONE, ONE, 0, 32'h2000_0000, 32'h1000_0000,
         mk(32'h1000_0000, 32'h2000_0000, 0, 0, 64));
    wait_done("neg_det");

    // diag(0.75,0.75), b = (0.5,-0.5): 2/3 truncated toward zero both signs
    send(32'h3000_0000, 0, 0, 32'h3000_0000, 32'h2000_0000, 32'hE000_0000,
         mk(32'h2AAA_AAAA, 32'hD555_5556, 0, 0, 64));
    wait_done("trunc");

    // Most-negative bx = -2.0: magnitude 2^31 flagged, result bits -2^31
    send(ONE, 0, 0, ONE, 32'h8000_0000, 0, mk(32'h8000_0000, 0, 0, 1, 64));
    wait_done("most_neg");

    // Back-pressure: hold out_ready low 10 cycles with in_valid pulsing
    out_ready = 1'b0;
    send(32'h2000_0000, 0, 0, 32'h2000_0000, 32'h1000_0000, 32'hF000_0000,
         mk(32'h2000_0000, 32'hE000_0000, 0, 0, 64));
    begin
      int n;
      n = 0;
      while (!out_valid && n < 200) begin
        @(negedge clk);
        n++;
      end
      if (!out_valid) tmo("stall_wait");
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = ~in_valid;
      x00 = 32'h1234_5678; bx = 32'h0BAD_F00D;
      #1;
      chk("stall_out_valid", out_valid, 1);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_ox", ox, 32'h2000_0000);
      chk("stall_oy", oy, 32'hE000_0000);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    wait_done("stall");

    // Reset 20 cycles into DIV: aborts with no result presented
    send(ONE, 0, 0, ONE, 32'h2000_0000, 32'hF000_0000,
         mk(32'h2000_0000, 32'hF000_0000, 0, 0, 64));
    repeat (21) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_in_ready", in_ready, 1);
    chk("abort_ox", ox, 0);
    chk("abort_oy", oy, 0);
    q.delete();
    @(negedge clk);
    rst = 1'b0;

    // Operation after the abort
    send(0, ONE, ONE, 0, 32'h2000_0000, 32'h1000_0000,
         mk(32'h1000_0000, 32'h2000_0000, 0, 0, 64));
    wait_done("after_abort");

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
